// File: rtl/soc_hash_stream.sv
// Streaming front-end for the Ascon hash core: packs W-bit lanes into padded R-bit blocks and streams the L-bit digest back out.
// Optional message bit counter output msg_bits is enabled by defining SOC_HASH_LEN_CNT_EN.
module soc_hash_stream #(
    parameter int R = 64,
    parameter int L = 256,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         empty_req,
    output logic [R-1:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ready,
    input  logic [L-1:0] dig_data,
    input  logic         dig_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
`ifdef SOC_HASH_LEN_CNT_EN
    ,
    output logic [31:0]  msg_bits
`endif
);
    localparam int N  = R / W;
    localparam int NO = L / W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (NO > 1) ? $clog2(NO) : 1;
    localparam logic [W-1:0] PAD_LANE = {1'b1, {(W-1){1'b0}}};
    localparam logic [R-1:0] PAD_BLK  = {1'b1, {(R-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FILL, SEND, PAD, WAIT_DIG, OUT} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic          pad_pending;
    logic [L-1:0]  digest;
    logic [R-1:0]  blk_fill;
    logic          take;

    assign in_ready  = (state == IDLE) || (state == FILL);
    assign blk_valid = (state == SEND) || (state == PAD);
    assign out_valid = (state == OUT);
    assign out_last  = (state == OUT) && (j == JW'(NO - 1));
    assign out_data  = digest[L-1 -: W];
    assign busy      = (state != IDLE);
    assign take      = in_valid && in_ready;

    // Current lane inserted at k; lanes above it zeroed, with the pad lane right after a final lane.
    always_comb begin
        blk_fill = blk_data;
        for (int i = 0; i < N; i++) begin
            if (i == int'(k))
                blk_fill[R-1-i*W -: W] = in_data;
            else if (i > int'(k))
                blk_fill[R-1-i*W -: W] = (in_last && i == int'(k) + 1) ? PAD_LANE : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= '0;
            j           <= '0;
            pad_pending <= 1'b0;
            blk_data    <= '0;
            blk_last    <= 1'b0;
            digest      <= '0;
`ifdef SOC_HASH_LEN_CNT_EN
            msg_bits    <= '0;
`endif
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (take) begin
                        blk_data <= blk_fill;
`ifdef SOC_HASH_LEN_CNT_EN
                        msg_bits <= (state == IDLE) ? 32'(W) : msg_bits + 32'(W);
`endif
                        if (k == KW'(N - 1)) begin
                            k           <= '0;
                            blk_last    <= 1'b0;
                            pad_pending <= in_last;
                            state       <= SEND;
                        end else if (in_last) begin
                            k        <= '0;
                            blk_last <= 1'b1;
                            state    <= SEND;
                        end else begin
                            k     <= k + KW'(1);
                            state <= FILL;
                        end
                    end else if (state == IDLE && empty_req) begin
                        blk_data <= PAD_BLK;
                        blk_last <= 1'b1;
`ifdef SOC_HASH_LEN_CNT_EN
                        msg_bits <= '0;
`endif
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (blk_ready) begin
                        if (pad_pending) begin
                            pad_pending <= 1'b0;
                            blk_data    <= PAD_BLK;
                            blk_last    <= 1'b1;
                            state       <= PAD;
                        end else if (blk_last) begin
                            state <= WAIT_DIG;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                PAD: begin
                    if (blk_ready)
                        state <= WAIT_DIG;
                end
                WAIT_DIG: begin
                    if (dig_valid) begin
                        digest <= dig_data;
                        j      <= '0;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    // Digest shifts left so the presented lane is always the top W bits.
                    if (out_ready) begin
                        digest <= {digest[L-W-1:0], {W{1'b0}}};
                        if (j == JW'(NO - 1)) begin
                            j     <= '0;
                            state <= IDLE;
                        end else begin
                            j <= j + JW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_hash_stream.sv
// Directed bench for soc_hash_stream (R=64, L=256, W=8); drives at posedge+1 and records handshakes at negedge.
module tb_soc_hash_stream;
    logic         clk = 0;
    logic         rst = 0;
    logic [7:0]   in_data = 0;
    logic         in_valid = 0, in_last = 0, in_ready, empty_req = 0;
    logic [63:0]  blk_data;
    logic         blk_valid, blk_last, blk_ready = 1;
    logic [255:0] dig_data = 0;
    logic         dig_valid = 0;
    logic [7:0]   out_data;
    logic         out_valid, out_last, out_ready = 0, busy;
`ifdef SOC_HASH_LEN_CNT_EN
    logic [31:0]  msg_bits;
`endif

    int checks = 0;
    int errors = 0;
    logic [64:0] blk_q[$];
    logic [8:0]  out_q[$];

    soc_hash_stream #(.R(64), .L(256), .W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .empty_req(empty_req),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .dig_data(dig_data), .dig_valid(dig_valid),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy)
`ifdef SOC_HASH_LEN_CNT_EN
        , .msg_bits(msg_bits)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && blk_valid && blk_ready) blk_q.push_back({blk_last, blk_data});
        if (rst && out_valid && out_ready) out_q.push_back({out_last, out_data});
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0; in_valid = 0; in_last = 0; empty_req = 0; dig_valid = 0; out_ready = 0; blk_ready = 1;
        step(); step();
        rst = 1;
        blk_q.delete(); out_q.delete();
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        in_data = d; in_valid = 1; in_last = l;
        while (!in_ready && n < 100) begin step(); n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL push_timeout lane=%h", d); end
        step();
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_blocks(input int cnt);
        int n = 0;
        while (blk_q.size() < cnt && n < 100) begin step(); n++; end
        checks++;
        if (blk_q.size() < cnt) begin errors++; $display("FAIL block_count got %0d want %0d", blk_q.size(), cnt); end
    endtask

    task automatic check_block(input int idx, input logic [63:0] d, input logic l);
        checks++;
        if (blk_q.size() <= idx || blk_q[idx] !== {l, d}) begin
            errors++;
            $display("FAIL block%0d got %h want %h", idx, (blk_q.size() > idx) ? blk_q[idx] : 65'h0, {l, d});
        end
    endtask

    function automatic logic [255:0] ramp();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[255-8*i -: 8] = 8'(i);
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, blk_valid, blk_last, out_valid, out_last, busy} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags got %b want 100000", {in_ready, blk_valid, blk_last, out_valid, out_last, busy});
        end
        checks++;
        if (blk_data !== 64'h0 || out_data !== 8'h0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0/0", blk_data, out_data);
        end
    endtask

    task automatic test_short_msg();
        push(8'h41, 0); push(8'h42, 0); push(8'h43, 1);
        checks++;
        if (blk_valid !== 1 || blk_data !== 64'h4142438000000000 || blk_last !== 1) begin
            errors++; $display("FAIL short_latency got v=%b d=%h l=%b want 1 4142438000000000 1", blk_valid, blk_data, blk_last);
        end
        wait_blocks(1);
        check_block(0, 64'h4142438000000000, 1);
        step();
        checks++;
        if ({busy, in_ready, blk_valid, out_valid} !== 4'b1000) begin
            errors++; $display("FAIL short_wait_dig got %b want 1000", {busy, in_ready, blk_valid, out_valid});
        end
`ifdef SOC_HASH_LEN_CNT_EN
        checks++;
        if (msg_bits !== 32'd24) begin errors++; $display("FAIL short_msg_bits got %0d want 24", msg_bits); end
`endif
    endtask

    task automatic test_digest_out();
        logic [7:0] held;
        logic       hold_chk = 0;
        int n = 0;
        dig_data = ramp(); dig_valid = 1;
        step();
        dig_valid = 0;
        checks++;
        if (out_valid !== 1 || out_data !== 8'h00) begin
            errors++; $display("FAIL dig_latency got v=%b d=%h want 1 00", out_valid, out_data);
        end
        while (out_q.size() < 32 && n < 200) begin
            if (hold_chk) begin
                checks++;
                if (out_data !== held) begin errors++; $display("FAIL out_hold got %h want %h", out_data, held); end
            end
            out_ready = (n % 2 == 0);
            held = out_data;
            hold_chk = !out_ready && out_valid;
            step(); n++;
        end
        out_ready = 0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (out_q.size() <= i || out_q[i] !== {(i == 31), 8'(i)}) begin
                errors++; $display("FAIL out_lane%0d got %h want %h", i, (out_q.size() > i) ? out_q[i] : 9'h0, {(i == 31), 8'(i)});
            end
        end
        checks++;
        if (out_valid !== 0 || busy !== 0 || in_ready !== 1) begin
            errors++; $display("FAIL out_done got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready);
        end
        out_q.delete(); blk_q.delete();
    endtask

    task automatic test_full_block();
        for (int i = 1; i <= 8; i++) push(8'(i), i == 8);
        wait_blocks(2);
        check_block(0, 64'h0102030405060708, 0);
        check_block(1, 64'h8000000000000000, 1);
        step();
        checks++;
        if ({busy, in_ready, blk_valid} !== 3'b100) begin
            errors++; $display("FAIL full_wait_dig got %b want 100", {busy, in_ready, blk_valid});
        end
    endtask

    task automatic test_reset_mid_out();
        int n = 0;
        dig_data = ramp(); dig_valid = 1;
        step();
        dig_valid = 0; out_ready = 1;
        while (out_q.size() < 10 && n < 100) begin step(); n++; end
        checks++;
        if (out_valid !== 1 || out_data !== 8'h0A) begin
            errors++; $display("FAIL mid_out_lane10 got v=%b d=%h want 1 0a", out_valid, out_data);
        end
        rst = 0; out_ready = 0;
        step();
        checks++;
        if (out_valid !== 0 || busy !== 0 || in_ready !== 1) begin
            errors++; $display("FAIL mid_out_reset got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready);
        end
        rst = 1;
        blk_q.delete(); out_q.delete();
        push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 1);
        wait_blocks(1);
        check_block(0, 64'hA1A2A38000000000, 1);
    endtask

    task automatic test_empty();
        do_reset();
        push(8'h11, 1);
        wait_blocks(1);
        do_reset();
        empty_req = 1;
        step();
        empty_req = 0;
        checks++;
        if (blk_valid !== 1 || blk_data !== 64'h8000000000000000 || blk_last !== 1) begin
            errors++; $display("FAIL empty_block got v=%b d=%h l=%b want 1 8000000000000000 1", blk_valid, blk_data, blk_last);
        end
        wait_blocks(1);
        check_block(0, 64'h8000000000000000, 1);
        do_reset();
        empty_req = 1;
        push(8'h55, 1);
        empty_req = 0;
        wait_blocks(1);
        check_block(0, 64'h5580000000000000, 1);
`ifdef SOC_HASH_LEN_CNT_EN
        checks++;
        if (msg_bits !== 32'd8) begin errors++; $display("FAIL lane_wins_msg_bits got %0d want 8", msg_bits); end
        do_reset();
        push(8'h22, 1);
        wait_blocks(1);
        do_reset();
        push(8'h33, 0); push(8'h34, 1);
        wait_blocks(1);
        step(); step();
        do_reset();
        empty_req = 1; step(); empty_req = 0;
        wait_blocks(1);
        checks++;
        if (msg_bits !== 32'd0) begin errors++; $display("FAIL empty_msg_bits got %0d want 0", msg_bits); end
`endif
        do_reset();
    endtask

    task automatic test_back_to_back_stall();
        blk_ready = 0;
        for (int i = 1; i <= 8; i++) push(8'(i), 0);
        in_data = 8'h09; in_valid = 1; in_last = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (blk_valid !== 1 || in_ready !== 0 || blk_data !== 64'h0102030405060708 || blk_last !== 0) begin
                errors++; $display("FAIL stall_hold cyc%0d got v=%b r=%b d=%h want 1 0 0102030405060708", c, blk_valid, in_ready, blk_data);
            end
            step();
        end
        blk_ready = 1;
        for (int i = 9; i <= 12; i++) push(8'(i), i == 12);
        wait_blocks(2);
        check_block(0, 64'h0102030405060708, 0);
        check_block(1, 64'h090A0B0C80000000, 1);
        checks++;
        if (blk_q.size() !== 2) begin errors++; $display("FAIL stall_block_total got %0d want 2", blk_q.size()); end
`ifdef SOC_HASH_LEN_CNT_EN
        checks++;
        if (msg_bits !== 32'd96) begin errors++; $display("FAIL stall_msg_bits got %0d want 96", msg_bits); end
`endif
    endtask

    initial begin
        test_reset();
        test_short_msg();
        test_digest_out();
        test_full_block();
        test_reset_mid_out();
        test_empty();
        test_back_to_back_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/soc_hash_stream.md
Name: soc_hash_stream

Overview:
Streaming SoC front-end for the Ascon hash core. It accepts a variable-length message as W-bit lanes with valid/ready/last and packs lanes into R-bit rate blocks with Ascon padding. It hands blocks to the hash core over a block handshake, latches the L-bit digest, and streams it back out as W-bit lanes. It replaces fixed-length, register-select byte loading with a true streaming interface.

Parameters:
R, 64, rate in bits (block width to core); R % W == 0
L, 256, digest length in bits; L % W == 0
W, 8, lane width in bits for message in and digest out

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_data  in  W  message lane, first lane of a block at blk_data[R-1 -: W]
in_valid  in  1  message lane valid
in_last  in  1  final lane of message
in_ready  out  1  lane accepted when in_valid & in_ready
empty_req  in  1  one-cycle request to hash the empty message (IDLE only)
blk_data  out  R  padded rate block to core
blk_valid  out  1  block valid
blk_last  out  1  block is final (padded) block
blk_ready  in  1  core accepts block
dig_data  in  L  digest from core
dig_valid  in  1  digest valid (sampled in WAIT_DIG only)
out_data  out  W  digest lane, MSB-first
out_valid  out  1  digest lane valid
out_last  out  1  final digest lane
out_ready  in  1  sink accepts lane
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst==0 at posedge): state IDLE; lane counter, blk_data, digest register cleared; all outputs 0 except in_ready=1. A reset mid-operation aborts; partial block and digest are discarded.
- States: IDLE, FILL, SEND, PAD, WAIT_DIG, OUT.
- in_ready = 1 in IDLE and FILL, 0 otherwise.
- Lane k (0-based in block) written to blk_data[R-1-k*W -: W]; N = R/W lanes per block.
- IDLE: accepted lane -> written at k=0, go FILL (or handle last as below). empty_req with no lane accepted -> blk_data = 1 followed by R-1 zeros, blk_last=1, go SEND. If in_valid and empty_req arrive together, the lane wins and empty_req is ignored.
- Accepted non-last lane filling k=N-1 -> SEND, blk_last=0.
- Accepted last lane at k<N-1 -> lane k+1 = {1'b1, zeros}, remaining lanes zero, blk_last=1, go SEND.
- Accepted last lane at k=N-1 -> SEND with blk_last=0, pad_pending set.
- SEND: blk_valid=1; blk_data and blk_last are held stable until blk_valid & blk_ready. On handshake: pad_pending -> PAD; blk_last -> WAIT_DIG; else -> FILL with k=0.
- PAD: blk_data = {1'b1, R-1 zeros}, blk_last=1, blk_valid=1; on handshake -> WAIT_DIG.
- WAIT_DIG: dig_valid -> latch dig_data, go OUT on the next cycle. dig_valid in any other state is ignored.
- OUT: out_valid=1; out_data = digest[L-1-j*W -: W] for lane j. On handshake j++; out_last=1 when j=L/W-1; handshake on the last lane -> IDLE, and out_valid drops the next cycle. out_data and out_last are held while out_ready=0.
- Minimum latency: a last lane accepted at cycle t gives blk_valid at t+1. dig_valid at cycle d gives out_valid at d+1.
- The lane counter wraps to 0 after each block handshake; there is no message length limit.

Optional Feature:
SOC_HASH_LEN_CNT_EN: when defined, adds output msg_bits[31:0], the count of message bits accepted (lanes*W). It is cleared when the first lane of a new message is accepted (or on empty_req), increments by W per accepted lane, wraps modulo 2^32, and holds its value until the next message. When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
R=64,W=8: lanes 0x41,0x42,0x43(last), blk_ready=1 -> one block 0x4142438000000000, blk_last=1, then WAIT_DIG.
8 lanes 0x01..0x08 with last on 0x08 -> block 0x0102030405060708 blk_last=0, then block 0x8000000000000000 blk_last=1.
empty_req in IDLE -> single block 0x8000000000000000 blk_last=1; msg_bits=0 when SOC_HASH_LEN_CNT_EN is defined.
blk_ready held low 5 cycles during SEND -> blk_data stable, in_ready=0, no lane lost; 12-lane message yields msg_bits=96.
L=256: dig_data=0x000102...1F, out_ready toggling 1/0 -> 32 lanes 0x00..0x1F in order, values held while stalled, out_last only on 0x1F, busy falls after it.
rst=0 mid-OUT (lane 10) -> next cycle out_valid=0, busy=0, in_ready=1; a new 3-byte message then gives the correct first block.
